// File: rtl/raycast_pkg.sv
// ============================================================================
// Module : raycast_pkg
// Brief  : Shared constants and map addressing helper for the raycaster.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package raycast_pkg;

  localparam int TILE_AIR   = 0;
  localparam int DEF_MAP_W  = 16;
  localparam int DEF_MAP_H  = 16;
  localparam int DEF_TILE_W = 8;

  // Row-major cell address.
  function automatic int cell_addr(input int x, input int y, input int map_w);
    return (y * map_w) + x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; search starts at the pointer, which moves past the winner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        grant_o[idx]   = 1'b1;
        grant_idx_o    = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (grant_idx_o == PW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/world_map_tracer.sv
// ============================================================================
// Module : world_map_tracer
// Brief  : Multi-channel tile-map query engine with per-channel first-hit latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module world_map_tracer
  import raycast_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                MAP_W       = DEF_MAP_W,
  parameter int                MAP_H       = DEF_MAP_H,
  parameter int                TILE_W      = DEF_TILE_W,
  parameter logic [TILE_W-1:0] BORDER_TILE = TILE_W'(1),
  localparam int               XW          = $clog2(MAP_W),
  localparam int               YW          = $clog2(MAP_H)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     setup_complete,
  input  logic [NUM_CH-1:0]        ch_new_ray,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*XW-1:0]     ch_x,
  input  logic [NUM_CH*YW-1:0]     ch_y,
  output logic [NUM_CH-1:0]        hit_valid,
  output logic [NUM_CH*XW-1:0]     hit_x,
  output logic [NUM_CH*YW-1:0]     hit_y,
  output logic [NUM_CH*TILE_W-1:0] hit_tile,
  input  logic                     wr_en,
  input  logic [XW-1:0]            wr_x,
  input  logic [YW-1:0]            wr_y,
  input  logic [TILE_W-1:0]        wr_tile
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        elig;
  logic [NUM_CH-1:0]        grant;
  logic [CW-1:0]            grant_idx;
  logic [XW-1:0]            sel_x;
  logic [YW-1:0]            sel_y;
  logic                     sel_oob;
  logic [AW-1:0]            rd_addr;
  logic                     wr_inb;
  logic [AW-1:0]            wr_addr;
  logic [TILE_W-1:0]        res_tile;

  logic [TILE_W-1:0]        mem_q [DEPTH];
  logic [TILE_W-1:0]        rdata_q;
  logic                     pipe_vld_q;
  logic [CW-1:0]            pipe_ch_q;
  logic [XW-1:0]            pipe_x_q;
  logic [YW-1:0]            pipe_y_q;
  logic                     pipe_oob_q;

  logic [NUM_CH-1:0]        hit_valid_q, hit_valid_d;
  logic [NUM_CH*XW-1:0]     hit_x_q, hit_x_d;
  logic [NUM_CH*YW-1:0]     hit_y_q, hit_y_d;
  logic [NUM_CH*TILE_W-1:0] hit_tile_q, hit_tile_d;

  // A pending write steals the whole cycle so a read never races the RAM update.
  assign elig = ch_valid & ~hit_valid_q & ~ch_new_ray & {NUM_CH{setup_complete & ~wr_en}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (elig),
    .advance_i   (1'b1),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign ch_ready = grant;
  assign sel_x    = ch_x[int'(grant_idx)*XW +: XW];
  assign sel_y    = ch_y[int'(grant_idx)*YW +: YW];
  assign sel_oob  = (int'(sel_x) >= MAP_W) || (int'(sel_y) >= MAP_H);
  assign rd_addr  = AW'(cell_addr(int'(sel_x), int'(sel_y), MAP_W));
  assign wr_inb   = (int'(wr_x) < MAP_W) && (int'(wr_y) < MAP_H);
  assign wr_addr  = AW'(cell_addr(int'(wr_x), int'(wr_y), MAP_W));

  always_ff @(posedge clk) begin
    if (wr_en && wr_inb) begin
      mem_q[wr_addr] <= wr_tile;
    end
  end

  always_ff @(posedge clk) begin
    if ((|grant) && !sel_oob) begin
      rdata_q <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= 1'b0;
      pipe_ch_q  <= '0;
      pipe_x_q   <= '0;
      pipe_y_q   <= '0;
      pipe_oob_q <= 1'b0;
    end else begin
      pipe_vld_q <= |grant;
      if (|grant) begin
        pipe_ch_q  <= grant_idx;
        pipe_x_q   <= sel_x;
        pipe_y_q   <= sel_y;
        pipe_oob_q <= sel_oob;
      end
    end
  end

  assign res_tile = pipe_oob_q ? BORDER_TILE : rdata_q;

  // Clearing (new ray or setup dropped) takes precedence over a returning result.
  always_comb begin
    hit_valid_d = hit_valid_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    hit_tile_d  = hit_tile_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!setup_complete || ch_new_ray[c]) begin
        hit_valid_d[c] = 1'b0;
      end else if (pipe_vld_q && (pipe_ch_q == CW'(c)) && !hit_valid_q[c] &&
                   (res_tile != TILE_W'(TILE_AIR))) begin
        hit_valid_d[c]                 = 1'b1;
        hit_x_d[c*XW +: XW]            = pipe_x_q;
        hit_y_d[c*YW +: YW]            = pipe_y_q;
        hit_tile_d[c*TILE_W +: TILE_W] = res_tile;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid_q <= '0;
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      hit_tile_q  <= '0;
    end else begin
      hit_valid_q <= hit_valid_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      hit_tile_q  <= hit_tile_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_x     = hit_x_q;
  assign hit_y     = hit_y_q;
  assign hit_tile  = hit_tile_q;

endmodule

`default_nettype wire

// File: tb/tb_world_map_tracer.sv
// ============================================================================
// Module : tb_world_map_tracer
// Brief  : Directed test of world_map_tracer; a 12-wide map makes x=12 reachable as out-of-bounds.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_world_map_tracer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setup_complete;
  logic [3:0]  ch_new_ray;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [15:0] ch_x;
  logic [15:0] ch_y;
  logic [3:0]  hit_valid;
  logic [15:0] hit_x;
  logic [15:0] hit_y;
  logic [31:0] hit_tile;
  logic        wr_en;
  logic [3:0]  wr_x;
  logic [3:0]  wr_y;
  logic [7:0]  wr_tile;

  int ntests = 0;
  int nfail  = 0;

  world_map_tracer #(
    .NUM_CH(4), .MAP_W(12), .MAP_H(16), .TILE_W(8), .BORDER_TILE(8'h01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .setup_complete(setup_complete),
    .ch_new_ray(ch_new_ray), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_x(ch_x), .ch_y(ch_y),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y), .hit_tile(hit_tile),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_tile(wr_tile)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int x, input int y);
    ch_x[c*4 +: 4] = 4'(x);
    ch_y[c*4 +: 4] = 4'(y);
  endtask

  task automatic clear_hits();
    ch_valid   = 4'b0000;
    ch_new_ray = 4'b1111;
    tick();
    ch_new_ray = 4'b0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; setup_complete = 1'b0; ch_new_ray = '0; ch_valid = 4'b1111;
    ch_x = '0; ch_y = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0;
    tick(); tick();
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL reset_hit_valid: got %b expected 0000", hit_valid); end
    ntests++; if ({hit_x, hit_y, hit_tile} !== 64'h0) begin nfail++; $display("FAIL reset_hit_data: got %h expected 0", {hit_x, hit_y, hit_tile}); end
    ntests++; if (ch_ready !== 4'b0000) begin nfail++; $display("FAIL reset_ready: got %b expected 0000", ch_ready); end
    rst_n = 1'b1;
    tick();
    ntests++; if (ch_ready !== 4'b0000) begin nfail++; $display("FAIL setup0_no_grant: got %b expected 0000", ch_ready); end
    ch_valid = 4'b0000;
  endtask

  // Map loaded while setup_complete=0: all air except (3,2)=05.
  task automatic load_map();
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 12; x++) begin
        wr_en = 1'b1; wr_x = 4'(x); wr_y = 4'(y);
        wr_tile = (x == 3 && y == 2) ? 8'h05 : 8'h00;
        tick();
      end
    end
    wr_en = 1'b0;
    setup_complete = 1'b1;
    tick();
  endtask

  task automatic test_single_hit();
    set_ch(0, 3, 2);
    ch_valid = 4'b0001;
    #1;
    ntests++; if (ch_ready !== 4'b0001) begin nfail++; $display("FAIL t1_ready: got %b expected 0001", ch_ready); end
    tick();
    ch_valid = 4'b0000;
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL t1_latency: got %b expected 0000", hit_valid); end
    tick();
    ntests++; if (hit_valid !== 4'b0001) begin nfail++; $display("FAIL t1_hit_valid: got %b expected 0001", hit_valid); end
    ntests++; if (hit_x[3:0] !== 4'd3 || hit_y[3:0] !== 4'd2) begin nfail++; $display("FAIL t1_hit_xy: got %0d,%0d expected 3,2", hit_x[3:0], hit_y[3:0]); end
    ntests++; if (hit_tile[7:0] !== 8'h05) begin nfail++; $display("FAIL t1_hit_tile: got %h expected 05", hit_tile[7:0]); end
    clear_hits();
    #1;
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL t1_new_ray_clear: got %b expected 0000", hit_valid); end
  endtask

  task automatic test_round_robin();
    int seq1 [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int seq2 [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    logic [3:0] exp;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    set_ch(0, 0, 0); set_ch(1, 1, 0); set_ch(2, 2, 0); set_ch(3, 4, 4);
    ch_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp = 4'b0001 << seq1[i];
      ntests++; if (ch_ready !== exp) begin nfail++; $display("FAIL rr_air[%0d]: got %b expected %b", i, ch_ready, exp); end
      tick();
    end
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL rr_air_no_hit: got %b expected 0000", hit_valid); end
    set_ch(2, 3, 2);
    for (int i = 0; i < 10; i++) begin
      #1;
      exp = 4'b0001 << seq2[i];
      ntests++; if (ch_ready !== exp) begin nfail++; $display("FAIL rr_skip[%0d]: got %b expected %b", i, ch_ready, exp); end
      tick();
    end
    ntests++; if (hit_valid !== 4'b0100) begin nfail++; $display("FAIL rr_ch2_hit: got %b expected 0100", hit_valid); end
    ntests++; if (hit_tile[23:16] !== 8'h05 || hit_x[11:8] !== 4'd3 || hit_y[11:8] !== 4'd2) begin
      nfail++; $display("FAIL rr_ch2_data: got tile %h x %0d y %0d expected 05 3 2", hit_tile[23:16], hit_x[11:8], hit_y[11:8]);
    end
    clear_hits();
  endtask

  task automatic test_write_priority();
    set_ch(1, 5, 5);
    ch_valid = 4'b0010;
    wr_en = 1'b1; wr_x = 4'd5; wr_y = 4'd5; wr_tile = 8'h07;
    #1;
    ntests++; if (ch_ready !== 4'b0000) begin nfail++; $display("FAIL wr_blocks_grant: got %b expected 0000", ch_ready); end
    tick();
    wr_en = 1'b0;
    #1;
    ntests++; if (ch_ready !== 4'b0010) begin nfail++; $display("FAIL wr_next_grant: got %b expected 0010", ch_ready); end
    tick();
    ch_valid = 4'b0000;
    tick();
    ntests++; if (hit_valid !== 4'b0010 || hit_tile[15:8] !== 8'h07) begin
      nfail++; $display("FAIL wr_new_data: got valid %b tile %h expected 0010 07", hit_valid, hit_tile[15:8]);
    end
    clear_hits();
  endtask

  task automatic test_oob();
    set_ch(0, 12, 0); set_ch(1, 11, 15);
    ch_valid = 4'b0011;
    repeat (4) tick();
    ntests++; if (hit_valid !== 4'b0001) begin nfail++; $display("FAIL oob_valid: got %b expected 0001", hit_valid); end
    ntests++; if (hit_tile[7:0] !== 8'h01 || hit_x[3:0] !== 4'd12 || hit_y[3:0] !== 4'd0) begin
      nfail++; $display("FAIL oob_data: got tile %h x %0d y %0d expected 01 12 0", hit_tile[7:0], hit_x[3:0], hit_y[3:0]);
    end
    // (13,0) would alias cell (1,1) if the out-of-bounds write were not dropped.
    ch_valid = 4'b0000;
    wr_en = 1'b1; wr_x = 4'd13; wr_y = 4'd0; wr_tile = 8'h09;
    tick();
    wr_en = 1'b0;
    set_ch(1, 1, 1);
    ch_valid = 4'b0010;
    repeat (3) tick();
    ntests++; if (hit_valid[1] !== 1'b0) begin nfail++; $display("FAIL oob_write_ignored: got %b expected 0", hit_valid[1]); end
    clear_hits();
  endtask

  task automatic test_new_ray_drop();
    set_ch(3, 5, 5);
    ch_valid = 4'b1000;
    #1;
    ntests++; if (ch_ready !== 4'b1000) begin nfail++; $display("FAIL nr_grant: got %b expected 1000", ch_ready); end
    tick();
    ch_valid = 4'b0000; ch_new_ray = 4'b1000;
    tick();
    ch_new_ray = 4'b0000;
    ntests++; if (hit_valid[3] !== 1'b0) begin nfail++; $display("FAIL nr_drop: got %b expected 0", hit_valid[3]); end
    tick();
    ntests++; if (hit_valid[3] !== 1'b0) begin nfail++; $display("FAIL nr_drop_late: got %b expected 0", hit_valid[3]); end
    ch_valid = 4'b1000;
    tick();
    ch_valid = 4'b0000;
    tick();
    ntests++; if (hit_valid !== 4'b1000 || hit_tile[31:24] !== 8'h07) begin
      nfail++; $display("FAIL nr_rehit: got valid %b tile %h expected 1000 07", hit_valid, hit_tile[31:24]);
    end
    clear_hits();
  endtask

  task automatic test_setup_drop();
    set_ch(0, 3, 2);
    ch_valid = 4'b0001;
    tick();
    setup_complete = 1'b0;
    #1;
    ntests++; if (ch_ready !== 4'b0000) begin nfail++; $display("FAIL setup_no_grant: got %b expected 0000", ch_ready); end
    tick();
    ch_valid = 4'b0000;
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL setup_drop_inflight: got %b expected 0000", hit_valid); end
    setup_complete = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    set_ch(0, 3, 2);
    ch_valid = 4'b0001;
    tick();
    ch_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    ntests++; if (hit_valid !== 4'b0000 || ch_ready !== 4'b0000 || {hit_x, hit_y, hit_tile} !== 64'h0) begin
      nfail++; $display("FAIL rst_mid_outputs: got valid %b ready %b data %h expected all 0", hit_valid, ch_ready, {hit_x, hit_y, hit_tile});
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    ntests++; if (hit_valid !== 4'b0000) begin nfail++; $display("FAIL rst_mid_no_hit: got %b expected 0000", hit_valid); end
    ch_valid = 4'b0001;
    tick();
    ch_valid = 4'b0000;
    tick();
    ntests++; if (hit_valid !== 4'b0001 || hit_tile[7:0] !== 8'h05) begin
      nfail++; $display("FAIL rst_mid_map_kept: got valid %b tile %h expected 0001 05", hit_valid, hit_tile[7:0]);
    end
  endtask

  initial begin
    test_reset();
    load_map();
    test_single_hit();
    test_round_robin();
    test_write_priority();
    test_oob();
    test_new_ray_drop();
    test_setup_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

`default_nettype wire
